// File: rtl/signed_accumulator_pkg.sv
// Shared constants and the clamp/wrap helper used by the accumulate and narrowing stages.
package signed_accumulator_pkg;

  localparam string DTYPE_FXP = "FXP";
  localparam string OPT_TRUE  = "TRUE";
  localparam string OPT_FALSE = "FALSE";

  // Working width for intermediate sums: one bit above the widest supported accumulator.
  localparam int MAXW = 65;

  // Fit a sign-extended value into a signed field of the given width, clamping or
  // wrapping on overflow; the result comes back sign-extended to MAXW bits.
  function automatic logic signed [MAXW-1:0] sat_narrow(
    input  logic signed [MAXW-1:0] value,
    input  int                     width,
    input  logic                   sat,
    output logic                   ovf
  );
    logic signed [MAXW-1:0] hi;
    logic signed [MAXW-1:0] lo;
    logic signed [MAXW-1:0] wrapped;
    hi      = (MAXW'(1) <<< (width - 1)) - MAXW'(1);
    lo      = ~hi;
    wrapped = (value <<< (MAXW - width)) >>> (MAXW - width);
    ovf     = (value > hi) || (value < lo);
    if (!ovf) begin
      sat_narrow = value;
    end else if (sat) begin
      sat_narrow = (value > hi) ? hi : lo;
    end else begin
      sat_narrow = wrapped;
    end
  endfunction

endpackage

// File: rtl/signed_acc_lane.sv
// One accumulator lane: accumulate/clear, sticky overflow, narrowing and optional output register.
module signed_acc_lane
  import signed_accumulator_pkg::*;
#(
  parameter string REG_OUTPUT = "TRUE",
  parameter string SATURATE   = "TRUE",
  parameter int    IN_WIDTH   = 20,
  parameter int    ACC_WIDTH  = 32,
  parameter int    OUT_WIDTH  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic                 in_valid,
  input  logic                 clear,
  input  logic [IN_WIDTH-1:0]  data_in,
  output logic [OUT_WIDTH-1:0] acc_out,
  output logic                 overflow
);

  localparam logic SAT = (SATURATE == OPT_TRUE);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
  logic signed [OUT_WIDTH-1:0] nar_q, nar_d;
  logic signed [MAXW-1:0]      base;
  logic                        ovf_q, ovf_d, add_ovf, nar_ovf;

  // The narrowed value is computed from the next accumulator so its overflow can join
  // the sticky flag in the same cycle as the accumulator overflow.
  always_comb begin
    base    = clear ? '0 : MAXW'(acc_q);
    add_ovf = 1'b0;
    nar_ovf = 1'b0;
    acc_d   = ACC_WIDTH'(sat_narrow(base + MAXW'($signed(data_in)), ACC_WIDTH, SAT, add_ovf));
    nar_d   = OUT_WIDTH'(sat_narrow(MAXW'(acc_d), OUT_WIDTH, SAT, nar_ovf));
    ovf_d   = (ovf_q & ~clear) | add_ovf | nar_ovf;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      nar_q <= '0;
      ovf_q <= 1'b0;
    end else if (enable && in_valid) begin
      acc_q <= acc_d;
      nar_q <= nar_d;
      ovf_q <= ovf_d;
    end else if (enable && clear) begin
      acc_q <= '0;
      nar_q <= '0;
      ovf_q <= 1'b0;
    end
  end

  if (REG_OUTPUT == OPT_TRUE) begin : g_reg_out
    logic [OUT_WIDTH-1:0] out_r;
    logic                 ovf_r;
    always_ff @(posedge clk) begin
      if (reset) begin
        out_r <= '0;
        ovf_r <= 1'b0;
      end else if (enable) begin
        out_r <= nar_q;
        ovf_r <= ovf_q;
      end
    end
    assign acc_out  = out_r;
    assign overflow = ovf_r;
  end else begin : g_direct_out
    assign acc_out  = nar_q;
    assign overflow = ovf_q;
  end

endmodule

// File: rtl/signed_accumulator.sv
// Multi-lane signed accumulator: LANES independent lanes sharing one valid pipeline.
module signed_accumulator
  import signed_accumulator_pkg::*;
#(
  parameter string DTYPE      = "FXP",
  parameter string REG_OUTPUT = "TRUE",
  parameter string SATURATE   = "TRUE",
  parameter int    LANES      = 4,
  parameter int    IN_WIDTH   = 20,
  parameter int    ACC_WIDTH  = 32,
  parameter int    OUT_WIDTH  = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic                       in_valid,
  input  logic                       clear,
  input  logic [LANES*IN_WIDTH-1:0]  data_in,
  output logic [LANES*OUT_WIDTH-1:0] acc_out,
  output logic                       out_valid,
  output logic [LANES-1:0]           overflow
);

  if (DTYPE != DTYPE_FXP) begin : g_bad_dtype
    $error("signed_accumulator: DTYPE must be \"FXP\"");
  end
  if ((REG_OUTPUT != OPT_TRUE && REG_OUTPUT != OPT_FALSE) ||
      (SATURATE != OPT_TRUE && SATURATE != OPT_FALSE)) begin : g_bad_option
    $error("signed_accumulator: REG_OUTPUT and SATURATE must be \"TRUE\" or \"FALSE\"");
  end
  if (LANES < 1 || LANES > 16 || ACC_WIDTH < IN_WIDTH || OUT_WIDTH > ACC_WIDTH ||
      ACC_WIDTH > MAXW - 1 || OUT_WIDTH < 1) begin : g_bad_width
    $error("signed_accumulator: illegal LANES/width combination");
  end

  logic acc_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      acc_valid <= 1'b0;
    end else if (enable) begin
      acc_valid <= in_valid;
    end
  end

  if (REG_OUTPUT == OPT_TRUE) begin : g_reg_valid
    logic out_valid_r;
    always_ff @(posedge clk) begin
      if (reset) begin
        out_valid_r <= 1'b0;
      end else if (enable) begin
        out_valid_r <= acc_valid;
      end
    end
    assign out_valid = out_valid_r;
  end else begin : g_direct_valid
    assign out_valid = acc_valid;
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    signed_acc_lane #(
      .REG_OUTPUT (REG_OUTPUT),
      .SATURATE   (SATURATE),
      .IN_WIDTH   (IN_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH),
      .OUT_WIDTH  (OUT_WIDTH)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .enable   (enable),
      .in_valid (in_valid),
      .clear    (clear),
      .data_in  (data_in[i*IN_WIDTH +: IN_WIDTH]),
      .acc_out  (acc_out[i*OUT_WIDTH +: OUT_WIDTH]),
      .overflow (overflow[i])
    );
  end

endmodule

// File: tb/tb_signed_accumulator.sv
// Five configurations driven with the same stimulus and checked every cycle against a behavioural model.
module tb_signed_accumulator;

  localparam int NC = 5;
  localparam int AW   [NC] = '{32, 24, 24, 24, 32};
  localparam int OW   [NC] = '{32, 24, 24, 16, 20};
  localparam bit SATC [NC] = '{1, 1, 0, 0, 1};
  localparam bit REGC [NC] = '{1, 1, 1, 0, 0};

  logic        clk = 1'b0;
  logic        rst, en, iv, clr;
  logic [39:0] din;

  logic [63:0] ao0;
  logic [47:0] ao1, ao2;
  logic [31:0] ao3;
  logic [39:0] ao4;
  logic        ovalid [NC];
  logic [1:0]  oflow  [NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signed_accumulator #(.DTYPE("FXP"), .REG_OUTPUT("TRUE"), .SATURATE("TRUE"), .LANES(2),
                       .IN_WIDTH(20), .ACC_WIDTH(32), .OUT_WIDTH(32)) d0 (
    .clk(clk), .reset(rst), .enable(en), .in_valid(iv), .clear(clr), .data_in(din),
    .acc_out(ao0), .out_valid(ovalid[0]), .overflow(oflow[0]));
  signed_accumulator #(.DTYPE("FXP"), .REG_OUTPUT("TRUE"), .SATURATE("TRUE"), .LANES(2),
                       .IN_WIDTH(20), .ACC_WIDTH(24), .OUT_WIDTH(24)) d1 (
    .clk(clk), .reset(rst), .enable(en), .in_valid(iv), .clear(clr), .data_in(din),
    .acc_out(ao1), .out_valid(ovalid[1]), .overflow(oflow[1]));
  signed_accumulator #(.DTYPE("FXP"), .REG_OUTPUT("TRUE"), .SATURATE("FALSE"), .LANES(2),
                       .IN_WIDTH(20), .ACC_WIDTH(24), .OUT_WIDTH(24)) d2 (
    .clk(clk), .reset(rst), .enable(en), .in_valid(iv), .clear(clr), .data_in(din),
    .acc_out(ao2), .out_valid(ovalid[2]), .overflow(oflow[2]));
  signed_accumulator #(.DTYPE("FXP"), .REG_OUTPUT("FALSE"), .SATURATE("FALSE"), .LANES(2),
                       .IN_WIDTH(20), .ACC_WIDTH(24), .OUT_WIDTH(16)) d3 (
    .clk(clk), .reset(rst), .enable(en), .in_valid(iv), .clear(clr), .data_in(din),
    .acc_out(ao3), .out_valid(ovalid[3]), .overflow(oflow[3]));
  signed_accumulator #(.DTYPE("FXP"), .REG_OUTPUT("FALSE"), .SATURATE("TRUE"), .LANES(2),
                       .IN_WIDTH(20), .ACC_WIDTH(32), .OUT_WIDTH(20)) d4 (
    .clk(clk), .reset(rst), .enable(en), .in_valid(iv), .clear(clr), .data_in(din),
    .acc_out(ao4), .out_valid(ovalid[4]), .overflow(oflow[4]));

  // Model: true running sum per lane, plus the result snapshot after the latest
  // and the previous enabled edge (outputs show one or the other by latency).
  longint macc     [NC][2];
  bit     movf     [NC][2];
  longint cur_val  [NC][2];
  longint prev_val [NC][2];
  bit     cur_ovf  [NC][2];
  bit     prev_ovf [NC][2];
  bit     cur_v    [NC];
  bit     prev_v   [NC];

  function automatic longint sx(longint v, int w);
    longint m;
    m = (longint'(1) << w) - 1;
    v = v & m;
    if (((v >> (w - 1)) & 1) != 0) v = v - (longint'(1) << w);
    return v;
  endfunction

  function automatic longint fit(longint s, int w, bit sat, output bit o);
    longint mx, mn;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    o  = (s > mx) || (s < mn);
    if (!o) return s;
    if (sat) return (s > mx) ? mx : mn;
    return sx(s, w);
  endfunction

  function automatic longint get_val(int c, int l);
    case (c)
      0: return sx(longint'(ao0[l*32 +: 32]), 32);
      1: return sx(longint'(ao1[l*24 +: 24]), 24);
      2: return sx(longint'(ao2[l*24 +: 24]), 24);
      3: return sx(longint'(ao3[l*16 +: 16]), 16);
      default: return sx(longint'(ao4[l*20 +: 20]), 20);
    endcase
  endfunction

  task automatic chk(string name, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic model_edge();
    longint x, s, n;
    bit o1, o2;
    for (int c = 0; c < NC; c++) begin
      if (rst) begin
        cur_v[c] = 0; prev_v[c] = 0;
        for (int l = 0; l < 2; l++) begin
          macc[c][l] = 0; movf[c][l] = 0;
          cur_val[c][l] = 0; prev_val[c][l] = 0; cur_ovf[c][l] = 0; prev_ovf[c][l] = 0;
        end
      end else if (en) begin
        prev_v[c] = cur_v[c];
        cur_v[c]  = iv;
        for (int l = 0; l < 2; l++) begin
          prev_val[c][l] = cur_val[c][l];
          prev_ovf[c][l] = cur_ovf[c][l];
          if (iv) begin
            x = sx(longint'(din[l*20 +: 20]), 20);
            s = (clr ? 0 : macc[c][l]) + x;
            s = fit(s, AW[c], SATC[c], o1);
            n = fit(s, OW[c], SATC[c], o2);
            macc[c][l] = s;
            movf[c][l] = (clr ? 1'b0 : movf[c][l]) | o1 | o2;
            cur_val[c][l] = n;
            cur_ovf[c][l] = movf[c][l];
          end else if (clr) begin
            macc[c][l] = 0; movf[c][l] = 0; cur_val[c][l] = 0; cur_ovf[c][l] = 0;
          end
        end
      end
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < NC; c++) begin
      chk($sformatf("d%0d.out_valid", c), longint'(ovalid[c]),
          longint'(REGC[c] ? prev_v[c] : cur_v[c]));
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("d%0d.lane%0d.acc_out", c, l), get_val(c, l),
            REGC[c] ? prev_val[c][l] : cur_val[c][l]);
        chk($sformatf("d%0d.lane%0d.overflow", c, l), longint'(oflow[c][l]),
            longint'(REGC[c] ? prev_ovf[c][l] : cur_ovf[c][l]));
      end
    end
  endtask

  // Inputs change just after a falling edge; model steps at the rising edge; outputs
  // are compared at the following falling edge.
  task automatic step(bit r, bit e, bit v, bit c, logic [19:0] l0, logic [19:0] l1);
    rst = r; en = e; iv = v; clr = c; din = {l1, l0};
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; iv = 1'b0; clr = 1'b0; din = '0;
    for (int i = 0; i < NC; i++) begin
      cur_v[i] = 0; prev_v[i] = 0;
      for (int l = 0; l < 2; l++) begin
        macc[i][l] = 0; movf[i][l] = 0;
        cur_val[i][l] = 0; prev_val[i][l] = 0; cur_ovf[i][l] = 0; prev_ovf[i][l] = 0;
      end
    end

    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("reset_acc_out", longint'(ao0), 0);
    chk("reset_out_valid", longint'(ovalid[0]), 0);
    chk("reset_overflow", longint'(oflow[0]), 0);

    // Basic accumulation, lane1 negative terms
    step(0, 1, 1, 0, 20'h01234, 20'hFFFFF);
    chk("lat_not_yet", longint'(ovalid[0]), 0);
    step(0, 1, 1, 0, 20'h00001, 20'hFFFFF);
    chk("first_valid", longint'(ovalid[0]), 1);
    chk("first_lane0", longint'(ao0[31:0]), 32'h00001234);
    chk("first_lane1", longint'(ao0[63:32]), 32'hFFFFFFFF);
    step(0, 1, 1, 0, 20'h00000, 20'hFFFFF);
    chk("second_lane0", longint'(ao0[31:0]), 32'h00001235);
    chk("second_lane1", longint'(ao0[63:32]), 32'hFFFFFFFE);
    step(0, 1, 0, 0, 0, 0);
    chk("third_lane1", longint'(ao0[63:32]), 32'hFFFFFFFD);
    chk("basic_overflow", longint'(oflow[0]), 0);

    // Saturation and wrap: clear, then 20 max-positive terms in lane0
    step(0, 1, 0, 1, 0, 0);
    for (int k = 1; k <= 20; k++) begin
      step(0, 1, 1, 0, 20'h7FFFF, 20'h00000);
      if (k == 17) begin
        chk("wrap_term16", longint'(ao2[23:0]), 24'h7FFFF0);
        chk("wrap_term16_ovf", longint'(oflow[2][0]), 0);
      end
      if (k == 18) begin
        chk("wrap_term17", longint'(ao2[23:0]), 24'h87FFEF);
        chk("wrap_term17_ovf", longint'(oflow[2][0]), 1);
        chk("sat_term17", longint'(ao1[23:0]), 24'h7FFFFF);
      end
    end
    step(0, 1, 0, 0, 0, 0);
    chk("sat_final", longint'(ao1[23:0]), 24'h7FFFFF);
    chk("sat_final_ovf", longint'(oflow[1][0]), 1);
    chk("wrap_final_ovf", longint'(oflow[2][0]), 1);
    step(0, 1, 1, 1, 20'h00005, 20'h00000);
    step(0, 1, 0, 0, 0, 0);
    chk("clear_term", longint'(ao1[23:0]), 5);
    chk("clear_ovf", longint'(oflow[1][0]), 0);

    // Stall: terms and clears offered while disabled are ignored
    step(0, 1, 1, 0, 20'h00007, 20'h00000);
    repeat (3) step(0, 0, 1, 1, 20'h00064, 20'h00064);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    chk("stall_hold", longint'(ao0[31:0]), 12);

    // Reset (with enable low) while a term is in flight
    step(0, 1, 1, 0, 20'h00009, 20'h00009);
    step(1, 0, 0, 0, 0, 0);
    chk("rst_flight_acc", longint'(ao0), 0);
    chk("rst_flight_valid", longint'(ovalid[0]), 0);
    step(0, 1, 0, 0, 0, 0);
    chk("rst_flight_after", longint'(ovalid[0]), 0);

    // Randomized traffic, biased toward extreme terms to exercise overflow paths
    for (int n = 0; n < 400; n++) begin
      logic [19:0] r0, r1;
      int sel0, sel1;
      sel0 = $urandom_range(0, 3);
      sel1 = $urandom_range(0, 3);
      r0 = (sel0 == 0) ? 20'h7FFFF : (sel0 == 1) ? 20'h80000 : 20'($urandom);
      r1 = (sel1 == 0) ? 20'h7FFFF : (sel1 == 1) ? 20'h80000 : 20'($urandom);
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 99) < 85),
           ($urandom_range(0, 99) < 70), ($urandom_range(0, 99) < 10), r0, r1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
